// File: rtl/acc_arbiter_pkg.sv
// Shared state encoding, default widths and index-width helper for the accumulator arbiter.
package acc_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_NUM_REQ    = 4;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/acc_arbiter_rr_pick.sv
// Combinational round-robin winner selection: first requester at or above ptr, else wrap to lowest.
module rr_pick
  import acc_arbiter_pkg::*;
#(
  parameter int NumReq = DEF_NUM_REQ,
  parameter int IdxW   = idx_width(NumReq)
) (
  input  logic [NumReq-1:0] req,
  input  logic [IdxW-1:0]   ptr,
  output logic              req_any,
  output logic [NumReq-1:0] onehot,
  output logic [IdxW-1:0]   idx
);

  logic [NumReq-1:0] upper_mask;
  logic [NumReq-1:0] masked;
  logic [NumReq-1:0] pool;

  genvar gi;
  generate
    for (gi = 0; gi < NumReq; gi++) begin : g_mask
      assign upper_mask[gi] = (IdxW'(gi) >= ptr);
    end
  endgenerate

  // Requests at or above the pointer take priority; only when none exist do we wrap.
  assign masked  = req & upper_mask;
  assign pool    = (|masked) ? masked : req;
  assign req_any = |req;

  always_comb begin
    onehot = '0;
    idx    = '0;
    for (int i = NumReq - 1; i >= 0; i--) begin
      if (pool[i]) begin
        onehot    = '0;
        onehot[i] = 1'b1;
        idx       = IdxW'(i);
      end
    end
  end

endmodule

// File: rtl/acc_arbiter.sv
// Round-robin arbiter giving NumReq requesters one-at-a-time access to an accumulator load port.
// Define ACC_ARBITER_LOCK_EN to add the Lock input for back-to-back read-modify-write writes.
module acc_arbiter
  import acc_arbiter_pkg::*;
#(
  parameter int DataWidth = DEF_DATA_WIDTH,
  parameter int NumReq    = DEF_NUM_REQ
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic [NumReq-1:0]           Req,
  input  logic [NumReq*DataWidth-1:0] ReqData,
`ifdef ACC_ARBITER_LOCK_EN
  input  logic [NumReq-1:0]           Lock,
`endif
  output logic [NumReq-1:0]           Grant,
  output logic [NumReq-1:0]           Ack,
  output logic                        ACCInEn,
  output logic [DataWidth-1:0]        ACCDataIn,
  input  logic                        ACCNeg,
  input  logic                        ACCZero,
  output logic                        ResultNeg,
  output logic                        ResultZero,
  output logic                        Busy
);

  localparam int              IdxW    = idx_width(NumReq);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NumReq - 1);

  state_e               state_q, state_d;
  logic [IdxW-1:0]      ptr_q, ptr_d;
  logic [IdxW-1:0]      winner_q, winner_d;
  logic [NumReq-1:0]    grant_q, grant_d;
  logic [NumReq-1:0]    ack_q, ack_d;
  logic                 acc_in_en_q, acc_in_en_d;
  logic [DataWidth-1:0] acc_data_q, acc_data_d;
  logic                 res_neg_q, res_neg_d;
  logic                 res_zero_q, res_zero_d;
  logic                 busy_q, busy_d;

  logic [DataWidth-1:0] req_data_arr [NumReq];
  logic                 pick_any;
  logic [NumReq-1:0]    pick_onehot;
  logic [IdxW-1:0]      pick_idx;
  logic                 lock_hold;
  logic [IdxW-1:0]      ptr_after;

  genvar gi;
  generate
    for (gi = 0; gi < NumReq; gi++) begin : g_slice
      assign req_data_arr[gi] = ReqData[gi*DataWidth +: DataWidth];
    end
  endgenerate

  rr_pick #(
    .NumReq (NumReq),
    .IdxW   (IdxW)
  ) u_pick (
    .req     (Req),
    .ptr     (ptr_q),
    .req_any (pick_any),
    .onehot  (pick_onehot),
    .idx     (pick_idx)
  );

`ifdef ACC_ARBITER_LOCK_EN
  assign lock_hold = Lock[winner_q] & Req[winner_q];
`else
  assign lock_hold = 1'b0;
`endif

  assign ptr_after = (winner_q == LastIdx) ? '0 : winner_q + IdxW'(1);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      winner_q    <= '0;
      grant_q     <= '0;
      ack_q       <= '0;
      acc_in_en_q <= 1'b0;
      acc_data_q  <= '0;
      res_neg_q   <= 1'b0;
      res_zero_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      winner_q    <= winner_d;
      grant_q     <= grant_d;
      ack_q       <= ack_d;
      acc_in_en_q <= acc_in_en_d;
      acc_data_q  <= acc_data_d;
      res_neg_q   <= res_neg_d;
      res_zero_q  <= res_zero_d;
      busy_q      <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pick_any) state_d = WRITE;
      WRITE:   state_d = DONE;
      DONE:    state_d = lock_hold ? WRITE : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Ack and result flags register on entry to DONE so they appear together in the DONE cycle.
  always_comb begin
    ptr_d       = ptr_q;
    winner_d    = winner_q;
    grant_d     = grant_q;
    ack_d       = '0;
    acc_in_en_d = 1'b0;
    acc_data_d  = acc_data_q;
    res_neg_d   = res_neg_q;
    res_zero_d  = res_zero_q;
    case (state_q)
      IDLE: begin
        grant_d = '0;
        if (pick_any) begin
          grant_d     = pick_onehot;
          winner_d    = pick_idx;
          acc_data_d  = req_data_arr[pick_idx];
          acc_in_en_d = 1'b1;
        end
      end
      WRITE: begin
        ack_d      = grant_q;
        res_neg_d  = ACCNeg;
        res_zero_d = ACCZero;
      end
      DONE: begin
        if (lock_hold) begin
          acc_data_d  = req_data_arr[winner_q];
          acc_in_en_d = 1'b1;
        end else begin
          grant_d = '0;
          ptr_d   = ptr_after;
        end
      end
      default: grant_d = '0;
    endcase
    busy_d = (state_d != IDLE);
  end

  assign Grant      = grant_q;
  assign Ack        = ack_q;
  assign ACCInEn    = acc_in_en_q;
  assign ACCDataIn  = acc_data_q;
  assign ResultNeg  = res_neg_q;
  assign ResultZero = res_zero_q;
  assign Busy       = busy_q;

endmodule

// File: tb/tb_acc_arbiter.sv
// Scoreboard bench for acc_arbiter: directed stimulus pushes expected transactions, a monitor checks them.
// Covers the ACC_ARBITER_LOCK_EN burst scenario when that macro is defined.
module tb_acc_arbiter;

  localparam int DW = 32;
  localparam int NR = 4;

  logic             clock = 1'b0;
  logic             reset_n = 1'b0;
  logic [NR-1:0]    req;
  logic [NR*DW-1:0] req_data;
`ifdef ACC_ARBITER_LOCK_EN
  logic [NR-1:0]    lock;
`endif
  logic [NR-1:0]    grant;
  logic [NR-1:0]    ack;
  logic             acc_in_en;
  logic [DW-1:0]    acc_data_in;
  logic             acc_neg;
  logic             acc_zero;
  logic             result_neg;
  logic             result_zero;
  logic             busy;

  logic [DW-1:0]    acc_model = '0;
  int               checks = 0;
  int               errors = 0;
  int               cyc = 0;

  typedef struct {
    int            idx;
    logic [DW-1:0] data;
    bit            neg;
    bit            zero;
    int            ack_cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  logic en_prev = 1'b0;

  acc_arbiter #(.DataWidth(DW), .NumReq(NR)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .Req        (req),
    .ReqData    (req_data),
`ifdef ACC_ARBITER_LOCK_EN
    .Lock       (lock),
`endif
    .Grant      (grant),
    .Ack        (ack),
    .ACCInEn    (acc_in_en),
    .ACCDataIn  (acc_data_in),
    .ACCNeg     (acc_neg),
    .ACCZero    (acc_zero),
    .ResultNeg  (result_neg),
    .ResultZero (result_zero),
    .Busy       (busy)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Accumulator stand-in: loads on the falling edge while ACCInEn is high.
  always @(negedge clock) if (acc_in_en) acc_model <= acc_data_in;
  assign acc_neg  = acc_model[DW-1];
  assign acc_zero = (acc_model == '0);

  initial begin
    #200000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req_v);
    checks++;
    if (act !== req_v) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req_v, cyc);
    end
  endtask

  task automatic push(input int idx, input logic [DW-1:0] data, input bit neg, input bit zero,
                      input int ack_cyc);
    exp_t e;
    e.idx = idx; e.data = data; e.neg = neg; e.zero = zero; e.ack_cyc = ack_cyc;
    exp_q.push_back(e);
    $display("txn queued: req=%0d data=%08h neg=%0d zero=%0d ack_cycle=%0d",
             idx, data, neg, zero, ack_cyc);
  endtask

  task automatic set_data(input int idx, input logic [DW-1:0] v);
    req_data[idx*DW +: DW] = v;
  endtask

  task automatic wait_cyc(input int k);
    while (cyc < k) @(negedge clock);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_grant"},       grant,       '0);
    chk({tag, "_ack"},         ack,         '0);
    chk({tag, "_accinen"},     acc_in_en,   '0);
    chk({tag, "_accdatain"},   acc_data_in, '0);
    chk({tag, "_resultneg"},   result_neg,  '0);
    chk({tag, "_resultzero"},  result_zero, 64'd1);
    chk({tag, "_busy"},        busy,        '0);
  endtask

  // Monitor: per-cycle invariants plus scoreboard comparison on every write and every Ack.
  always @(posedge clock) begin
    #2;
    if (reset_n) begin
      chk("grant_onehot0", 64'($onehot0(grant)), 64'd1);
      if (acc_in_en) begin
        chk("write_single_cycle", en_prev, '0);
        chk("write_busy", busy, 64'd1);
        if (exp_q.size() == 0) begin
          chk("write_without_txn", acc_in_en, '0);
        end else begin
          chk("write_grant", grant, 64'(1) << exp_q[0].idx);
          chk("write_data", acc_data_in, exp_q[0].data);
        end
      end
      if (ack != '0) begin
        if (exp_q.size() == 0) begin
          chk("ack_without_txn", ack, '0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("ack_onehot", ack, 64'(1) << mon_e.idx);
          chk("ack_cycle", cyc, mon_e.ack_cyc);
          chk("ack_after_write", en_prev, 64'd1);
          chk("ack_grant_held", grant, 64'(1) << mon_e.idx);
          chk("ack_data_held", acc_data_in, mon_e.data);
          chk("ack_busy", busy, 64'd1);
          chk("result_neg", result_neg, mon_e.neg);
          chk("result_zero", result_zero, mon_e.zero);
          $display("ack: req=%0d data=%08h neg=%0d zero=%0d cycle=%0d",
                   mon_e.idx, acc_data_in, result_neg, result_zero, cyc);
        end
      end
      en_prev = acc_in_en;
    end else begin
      en_prev = 1'b0;
    end
  end

  initial begin
    int c;
    req      = '0;
    req_data = '0;
`ifdef ACC_ARBITER_LOCK_EN
    lock     = '0;
`endif
    reset_n  = 1'b0;
    repeat (2) @(negedge clock);
    check_reset_outputs("reset");
    reset_n = 1'b1;
    @(negedge clock);

    // Single request with a negative value; pointer advances to 3.
    set_data(2, 32'h8000_0001);
    req = 4'b0100;
    c = cyc;
    push(2, 32'h8000_0001, 1'b1, 1'b0, c + 2);
    wait_cyc(c + 1);
    req = '0;
    wait_cyc(c + 3);

    // Pointer 3 favours requester 3 over 0; Req[3] dropped and its data changed mid-write.
    set_data(3, 32'h0000_0005);
    set_data(0, 32'h0000_0007);
    req = 4'b1001;
    c = cyc;
    push(3, 32'h0000_0005, 1'b0, 1'b0, c + 2);
    push(0, 32'h0000_0007, 1'b0, 1'b0, c + 5);
    wait_cyc(c + 1);
    req[3] = 1'b0;
    set_data(3, 32'hDEAD_BEEF);
    wait_cyc(c + 4);
    req[0] = 1'b0;
    wait_cyc(c + 6);

    // Zero data from requester 1.
    set_data(1, 32'h0000_0000);
    req = 4'b0010;
    c = cyc;
    push(1, 32'h0000_0000, 1'b0, 1'b1, c + 2);
    wait_cyc(c + 1);
    req = '0;
    wait_cyc(c + 3);

    // Reset asserted during WRITE: the transaction is abandoned with no Ack.
    set_data(2, 32'h0000_1234);
    req = 4'b0100;
    c = cyc;
    push(2, 32'h0000_1234, 1'b0, 1'b0, c + 2);
    @(posedge clock);
    #3;
    reset_n = 1'b0;
    req = '0;
    #1;
    check_reset_outputs("midwrite_reset");
    exp_q.delete();
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    wait_cyc(cyc + 3);

    // All requesters continuously: grants 0,1,2,3,0 every 3 cycles from pointer 0.
    set_data(0, 32'h0000_0010);
    set_data(1, 32'hFFFF_FFF0);
    set_data(2, 32'h0000_0000);
    set_data(3, 32'h7FFF_FFFF);
    req = 4'b1111;
    c = cyc;
    push(0, 32'h0000_0010, 1'b0, 1'b0, c + 2);
    push(1, 32'hFFFF_FFF0, 1'b1, 1'b0, c + 5);
    push(2, 32'h0000_0000, 1'b0, 1'b1, c + 8);
    push(3, 32'h7FFF_FFFF, 1'b0, 1'b0, c + 11);
    push(0, 32'h0000_0010, 1'b0, 1'b0, c + 14);
    wait_cyc(c + 13);
    req = '0;
    wait_cyc(c + 16);

`ifdef ACC_ARBITER_LOCK_EN
    // Locked requester 0 writes every 2 cycles until Lock drops, then requester 1 is granted.
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    set_data(0, 32'h8000_0000);
    set_data(1, 32'hFFFF_FFFF);
    lock = 4'b0001;
    req  = 4'b0011;
    c = cyc;
    push(0, 32'h8000_0000, 1'b1, 1'b0, c + 2);
    push(0, 32'h0000_0000, 1'b0, 1'b1, c + 4);
    push(0, 32'h0000_0001, 1'b0, 1'b0, c + 6);
    push(1, 32'hFFFF_FFFF, 1'b1, 1'b0, c + 9);
    wait_cyc(c + 2);
    set_data(0, 32'h0000_0000);
    wait_cyc(c + 4);
    set_data(0, 32'h0000_0001);
    wait_cyc(c + 6);
    lock = '0;
    wait_cyc(c + 8);
    req = '0;
    wait_cyc(c + 11);
`endif

    wait_cyc(cyc + 3);
    chk("scoreboard_drained", exp_q.size(), '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
